serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-cycle successor to the single-bit adder cell: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a registered carry between digit steps.
- Operands enter and results leave on valid/ready handshakes, so the block drops into streaming datapaths.
- Intended as the area-cheap arithmetic unit for the CADD datapath, where a full-width combinational adder is too large.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- DIGIT, 2, bits added per cycle; must divide WIDTH exactly.
- NSTEP, derived (WIDTH/DIGIT), number of RUN cycles; localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle a/b/cin valid.
- in_ready  output  1  block can accept an operand bundle.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset values: state = IDLE; in_ready = 1; out_valid = 0; sum = 0; cout = 0; step counter = 0; internal shift registers = 0.
- States and transitions:
  - IDLE: in_ready = 1. If in_valid = 1 at an edge, capture a, b, cin into the shift regs/carry reg, clear the counter, and go to RUN.
  - RUN: in_ready = 0, out_valid = 0. Each cycle:
    - add the low DIGIT bits of the A and B regs plus the carry reg;
    - shift the DIGIT-bit result into the top of the sum reg;
    - shift the A and B regs right by DIGIT;
    - update the carry reg;
    - increment the counter.
  - After the NSTEP-th RUN cycle (counter = NSTEP-1 at that edge), go to DONE.
  - DONE: out_valid = 1; sum and cout are stable and held. If out_ready = 1 at an edge, go to IDLE. Otherwise hold indefinitely (backpressure).
- Latency: handshake accepted at edge T; out_valid goes high after edge T+NSTEP. Minimum spacing between accepted bundles is NSTEP+2 cycles.
- in_ready depends only on state, never combinationally on in_valid. out_valid depends only on state.
- Inputs a/b/cin are ignored outside the IDLE capture edge; changes during RUN/DONE have no effect.
- sum/cout update only on the transition into DONE. From the moment they are valid until out_ready is seen, they hold the result.
- Arithmetic: unsigned, modulo 2^WIDTH; cout is the true (WIDTH+1)-th bit. WIDTH = DIGIT gives NSTEP = 1 (single RUN cycle).
- rst asserted in any state, including mid-RUN or during DONE stall: the next state is IDLE with all reset values. The partial result is discarded, and no out_valid is produced for the abandoned operation.
- rst has priority over any simultaneous handshake.
- Illegal parameters (WIDTH % DIGIT ≠ 0, or DIGIT < 1) are an elaboration-time $error.

Optional Feature:
- SERIAL_ADDER_OVF_EN defined:
  - Adds output port ovf (1 bit), the two's-complement signed overflow of a + b + cin: carry into the MSB XOR carry out of the MSB.
  - Registered alongside sum/cout; reset 0; valid with out_valid and held with it.
- SERIAL_ADDER_OVF_EN undefined: no ovf port and no related logic; all other behaviour is identical.

Decomposition:
- Package serial_adder_pkg:
  - state enum state_t {IDLE, RUN, DONE}, 2 bits;
  - helper function clog2-based counter-width constant.
- Sub-module digit_adder: a combinational DIGIT-bit ripple adder (parameter DIGIT; ports x, y, ci, s, co), built from the existing single-bit adder style. It is instantiated once and shared across steps.
  - With SERIAL_ADDER_OVF_EN, digit_adder also exposes the carry into its top bit, c_msb_in.
- Counter, shift regs and FSM stay in serial_adder.

Test Plan (WIDTH=8, DIGIT=2 unless noted):
- Reset released, a=8'h00, b=8'h00, cin=0, in_valid pulse → out_valid rises exactly 4 cycles after accept; sum=8'h00, cout=0; in_ready low from the edge after accept until return to IDLE.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1; with SERIAL_ADDER_OVF_EN, ovf=0.
- a=8'h7F, b=8'h00, cin=1 → sum=8'h80, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid with a=8'h3C, b=8'hA5, cin=1 → sum=8'hE2, cout=0 held unchanged all 10 cycles; in_ready stays 0; a/b toggled meanwhile have no effect.
- Reset mid-RUN (assert rst on the 2nd RUN cycle) → next cycle in_ready=1, out_valid=0, sum=0, cout=0. A fresh op 8'h10+8'h20 then yields sum=8'h30.
- WIDTH=16, DIGIT=16, plus 200 random back-to-back bundles with random out_ready → each result matches a scoreboard (a+b+cin); NSTEP=1 latency holds.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and helpers for the digit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_digit_adder.sv
`default_nettype none
// ============================================================================
// Module      : digit_adder
// Description : Combinational DIGIT-bit ripple adder built from full-adder
//               cells. Optional macro SERIAL_ADDER_OVF_EN exposes c_msb_in.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             c_msb_in
`endif
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (x[i] & w_c[i]) | (y[i] & w_c[i]);
    end

    assign co = w_c[DIGIT];

`ifdef SERIAL_ADDER_OVF_EN
    assign c_msb_in = w_c[DIGIT-1];
`endif

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Digit-serial adder with valid/ready handshakes, DIGIT bits
//               per cycle. Optional macro SERIAL_ADDER_OVF_EN adds port ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    // Guarded divisor keeps elaboration alive long enough to report bad params.
    localparam int DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int NSTEP    = WIDTH / DIG_SAFE;
    localparam int CW       = cnt_width(NSTEP);

    if ((DIGIT < 1) || (WIDTH < 1) || ((WIDTH % DIG_SAFE) != 0)) begin : g_bad_params
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_acc_next;

`ifdef SERIAL_ADDER_OVF_EN
    logic             w_c_msb_in;
    logic             r_ovf;
`endif

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x        (r_a[DIGIT-1:0]),
        .y        (r_b[DIGIT-1:0]),
        .ci       (r_carry),
        .s        (w_s),
        .co       (w_co)
`ifdef SERIAL_ADDER_OVF_EN
       ,.c_msb_in (w_c_msb_in)
`endif
    );

    // New digit enters at the top; after NSTEP steps the LSB digit is at bit 0.
    assign w_acc_next = WIDTH'({w_s, r_acc} >> DIGIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= cin;
                        r_cnt      <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_co;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CW'(NSTEP - 1)) begin
                        r_sum       <= w_acc_next;
                        r_cout      <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf       <= w_co ^ w_c_msb_in;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed checks on an 8/2 adder plus random bundles on a
//               16/16 adder. Honours SERIAL_ADDER_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       in_valid0 = 1'b0, out_ready0 = 1'b0, cin0 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0;
    logic       in_ready0, out_valid0, cout0;
    logic [7:0] sum0;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b0, cin1 = 1'b0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        in_ready1, out_valid1, cout1;
    logic [15:0] sum1;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf0, ovf1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(2)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .a         (a0),
        .b         (b0),
        .cin       (cin0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .sum       (sum0),
        .cout      (cout0)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf       (ovf0)
`endif
    );

    serial_adder #(.WIDTH(16), .DIGIT(16)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf       (ovf1)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one bundle on dut0, wait for the result and check it (no release).
    task automatic run_op0(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                           input logic tc, input logic [7:0] es, input logic ec, input logic eo);
        int cyc;
        check({tag, ".in_ready_idle"}, 32'(in_ready0), 32'd1);
        a0 = ta; b0 = tb; cin0 = tc; in_valid0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        check({tag, ".in_ready_run"}, 32'(in_ready0), 32'd0);
        cyc = 0;
        while (out_valid0 !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'd4);
        check({tag, ".sum"},  32'(sum0),  32'(es));
        check({tag, ".cout"}, 32'(cout0), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, ".ovf"},  32'(ovf0),  32'(eo));
`else
        if (eo === 1'bx) check({tag, ".ovf_arg"}, 32'(eo), 32'd0);
`endif
    endtask

    task automatic release0(input string tag);
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
        check({tag, ".in_ready_back"}, 32'(in_ready0), 32'd1);
        check({tag, ".out_valid_drop"}, 32'(out_valid0), 32'd0);
    endtask

    initial begin
        logic [16:0] full;
        logic        exp_ovf;
        int          stall;

        repeat (3) step();
        check("reset.in_ready",  32'(in_ready0),  32'd1);
        check("reset.out_valid", 32'(out_valid0), 32'd0);
        check("reset.sum",       32'(sum0),       32'd0);
        check("reset.cout",      32'(cout0),      32'd0);
        rst = 1'b0;
        step();

        run_op0("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        release0("zero");
        run_op0("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        release0("ff_01");
        run_op0("7f_cin", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
        release0("7f_cin");

        // Hold the result under backpressure while inputs churn.
        run_op0("bp", 8'h3C, 8'hA5, 1'b1, 8'hE2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom); in_valid0 = 1'b1;
            step();
            check("bp.sum_held",  32'(sum0),       32'hE2);
            check("bp.cout_held", 32'(cout0),      32'd0);
            check("bp.in_ready",  32'(in_ready0),  32'd0);
            check("bp.out_valid", 32'(out_valid0), 32'd1);
        end
        in_valid0 = 1'b0;
        release0("bp");

        // Reset during the second RUN cycle abandons the operation.
        a0 = 8'h55; b0 = 8'hAA; cin0 = 1'b1; in_valid0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst.in_ready",  32'(in_ready0),  32'd1);
        check("midrst.out_valid", 32'(out_valid0), 32'd0);
        check("midrst.sum",       32'(sum0),       32'd0);
        check("midrst.cout",      32'(cout0),      32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst.no_result", 32'(out_valid0), 32'd0);
        end
        run_op0("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        release0("after_rst");

        // WIDTH=16, DIGIT=16: single RUN cycle, random data and stalls.
        for (int i = 0; i < 200; i++) begin
            check("w16.in_ready_idle", 32'(in_ready1), 32'd1);
            a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
            full    = 17'(a1) + 17'(b1) + 17'(cin1);
            exp_ovf = (a1[15] == b1[15]) && (full[15] != a1[15]);
            in_valid1 = 1'b1;
            step();
            in_valid1 = 1'b0;
            check("w16.in_ready_run", 32'(in_ready1),  32'd0);
            check("w16.early_valid",  32'(out_valid1), 32'd0);
            step();
            check("w16.latency", 32'(out_valid1), 32'd1);
            stall = int'($urandom_range(0, 3));
            for (int k = 0; k < stall; k++) begin
                a1 = 16'($urandom); b1 = 16'($urandom);
                step();
            end
            check("w16.sum",  32'(sum1),  32'(full[15:0]));
            check("w16.cout", 32'(cout1), 32'(full[16]));
`ifdef SERIAL_ADDER_OVF_EN
            check("w16.ovf",  32'(ovf1),  32'(exp_ovf));
`endif
            out_ready1 = 1'b1;
            step();
            out_ready1 = 1'b0;
            check("w16.out_valid_drop", 32'(out_valid1), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
